// File: rtl/fir_pkg.sv
// Shared configuration for the FIR multiply-accumulate engine: default filter
// dimensions, derived widths and the engine state encoding.
package fir_pkg;

    localparam int NUMBER_OF_TAPS = 64;
    localparam int COEFF_BITS     = 16;
    localparam int DATA_BITS      = 16;

    localparam int COUNTER_BITS   = $clog2(NUMBER_OF_TAPS);
    localparam int PROD_BITS      = DATA_BITS + COEFF_BITS;
    // One extra bit per doubling of the tap count keeps the full sum exact.
    localparam int ACC_BITS       = PROD_BITS + COUNTER_BITS;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer for the FIR engine. One write port and one
// combinational read port addressed as (base - offset) modulo DEPTH, so the
// caller can walk backwards in time from the newest sample.
module fir_delay_line #(
    parameter int DEPTH    = 64,
    parameter int WIDTH    = 16,
    localparam int PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [PTR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [PTR_BITS-1:0] base,
    input  logic [PTR_BITS-1:0] offset,
    output logic [WIDTH-1:0]    rd_data
);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] rd_addr;

    // DEPTH is a power of two, so the subtraction wraps naturally.
    assign rd_addr = base - offset;
    assign rd_data = mem[rd_addr];

    // Sample storage: cleared on reset, one write per accepted sample.
    // NOTE: every entry is reset so no pre-reset sample can leak into a later
    // response; this makes the buffer flops rather than RAM, which is intended.
    // NOTE: state is written with non-blocking assignments so all flops
    // update together at the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/fir_mac_engine.sv
// Time-multiplexed multiply-accumulate stage of the FIR filter. Accepts one
// sample, sweeps current_count over all taps accumulating sample*coeff, then
// offers the full-precision sum through a valid/ready handshake.
// Optional build macro FIR_MAC_PIPE_EN registers the product before the
// accumulator (one extra drain cycle, identical results).
module fir_mac_engine
    import fir_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_BITS-1:0]    i_sample,
    input  logic                    i_sample_valid,
    output logic                    o_sample_ready,
    output logic [COUNTER_BITS-1:0] current_count,
    input  logic [COEFF_BITS-1:0]   coeff,
    output logic [ACC_BITS-1:0]     o_result,
    output logic                    o_result_valid,
    input  logic                    i_result_ready
);

    localparam logic [COUNTER_BITS-1:0] LAST_TAP = COUNTER_BITS'(NUMBER_OF_TAPS - 1);

    state_t                     state;
    state_t                     state_next;
    logic [COUNTER_BITS-1:0]    wr_ptr;
    logic signed [ACC_BITS-1:0] acc;
    logic signed [ACC_BITS-1:0] acc_add;
    logic [DATA_BITS-1:0]       tap_sample;
    logic signed [PROD_BITS-1:0] prod;
    logic signed [ACC_BITS-1:0] prod_ext;
    logic                       sample_accept;
    logic                       mac_last;
    logic                       result_take;

    fir_delay_line #(
        .DEPTH (NUMBER_OF_TAPS),
        .WIDTH (DATA_BITS)
    ) u_delay_line (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (sample_accept),
        .wr_addr (wr_ptr),
        .wr_data (i_sample),
        .base    (wr_ptr),
        .offset  (current_count),
        .rd_data (tap_sample)
    );

    // Signed product of the tap sample and the coefficient returned for
    // current_count in the same cycle, sign-extended to accumulator width.
    assign prod     = $signed(tap_sample) * $signed(coeff);
    assign prod_ext = {{(ACC_BITS - PROD_BITS){prod[PROD_BITS-1]}}, prod};

    // The valid flag only rises in OUT, so this is the handshake completing.
    assign result_take = o_result_valid && i_result_ready;

`ifdef FIR_MAC_PIPE_EN
    logic signed [ACC_BITS-1:0] prod_q;
    logic                       prod_vld;
    logic                       drain;

    // Product pipeline stage; after the last tap one drain cycle empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q   <= '0;
            prod_vld <= 1'b0;
            drain    <= 1'b0;
        end else if (sample_accept) begin
            prod_vld <= 1'b0;
            drain    <= 1'b0;
        end else if (state == MAC) begin
            prod_q   <= prod_ext;
            prod_vld <= !drain;
            if (current_count == LAST_TAP) begin
                drain <= 1'b1;
            end
        end
    end

    assign acc_add  = prod_vld ? prod_q : '0;
    assign mac_last = drain;
`else
    assign acc_add  = prod_ext;
    assign mac_last = (current_count == LAST_TAP);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment first keeps this block purely combinational
    // on every path, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_sample_valid) state_next = MAC;
            MAC:     if (mac_last)       state_next = OUT;
            OUT:     if (result_take)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs and strobes.
    always_comb begin
        o_sample_ready = (state == IDLE);
        sample_accept  = o_sample_ready && i_sample_valid;
    end

    // Datapath: tap counter, accumulator, write pointer and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            current_count  <= '0;
            wr_ptr         <= '0;
            acc            <= '0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_accept) begin
                        acc           <= '0;
                        current_count <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + acc_add;
                    if (current_count != LAST_TAP) begin
                        current_count <= current_count + 1'b1;
                    end
                end
                OUT: begin
                    if (!o_result_valid) begin
                        o_result       <= acc;
                        o_result_valid <= 1'b1;
                    end else if (i_result_ready) begin
                        o_result_valid <= 1'b0;
                        wr_ptr         <= wr_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
